multi_way_traffic_controller: RTL
=================================

// Module: multi_way_traffic_controller
// PURPOSE
//  Parametrised N-way intersection light controller; successor to the 2-way highway/farm FSM.
//  Grants green to one approach at a time, round-robin among approaches whose vehicle sensor is set.
//  Enforces min/max green, yellow and all-red clearance, with an emergency-preemption override.
//  Sits at top level of the intersection design and drives lamp outputs directly.
// PARAMETERS
//  N_WAYS    4   number of approaches (2..8)
//  CNT_W     8   phase-timer width; every timing parameter must be < 2**CNT_W
//  GREEN_MIN 8   minimum green cycles (>=1)
//  GREEN_MAX 32  green cycles after which a waiting approach forces handover (>=GREEN_MIN)
//  YELLOW_T  3   yellow cycles (>=1)
//  ALLRED_T  2   all-red clearance cycles (>=1)
//  MAIN_WAY  0   default approach when no sensor is set
// PORTS
//  clk            in   1         clock; all state updates on rising edge
//  reset          in   1         synchronous, active-high reset
//  sensor         in   N_WAYS    bit i = vehicle waiting on approach i
//  emergency_req  in   1         preemption request
//  emergency_way  in   WAY_W     requested approach, WAY_W = $clog2(N_WAYS)
//  lights         out  3*N_WAYS  lights[3i+2:3i]: 3'b100 red, 3'b010 yellow, 3'b001 green
//  active_way     out  WAY_W     approach currently (or last) granted
//  phase          out  2         0 ALL_RED, 1 GREEN, 2 YELLOW
// BEHAVIOUR
//  - All outputs registered. Reset: lights all 3'b100, phase ALL_RED, timer 0, active_way MAIN_WAY.
//  - Phase timer clears on every phase entry and increments each cycle.
//  - ALL_RED: lasts exactly ALLRED_T cycles. On the last cycle the next way is chosen:
//    valid emergency (emergency_req=1, emergency_way<N_WAYS) -> emergency_way;
//    else first set sensor bit searching active_way+1, +2, ... mod N_WAYS, active_way checked last;
//    else MAIN_WAY. Next cycle: phase GREEN, chosen way 3'b001.
//  - GREEN: let others = sensor with active_way bit masked.
//    valid emergency for another way -> YELLOW next cycle regardless of timer;
//    valid emergency for active_way -> stay GREEN, GREEN_MAX ignored;
//    timer>=GREEN_MIN-1 and others!=0 -> YELLOW; GREEN_MAX handover is covered by this rule
//    since GREEN_MAX>=GREEN_MIN; others==0 -> stay GREEN indefinitely, timer saturates at GREEN_MAX-1.
//  - YELLOW: active way 3'b010 for exactly YELLOW_T cycles, then ALL_RED.
//  - Invariant: at most one approach non-red in any cycle; a yellow phase always precedes
//    all-red, which always precedes green.
//  - Emergency arriving in YELLOW/ALL_RED does not shorten them; it only steers the ALL_RED pick.
//    Emergency withdrawn before the pick -> normal round-robin.
//  - Out-of-range emergency_way: request ignored entirely.
//  - Reset mid-phase: next cycle is the reset state; no yellow is shown.
//  - Sensors and emergency inputs are sampled only at clock edges; no latching of short pulses.
// STRUCTURE
//  - traffic_pkg: phase enum (ALL_RED/GREEN/YELLOW), lamp constants LAMP_RED/LAMP_YEL/LAMP_GRN.
//  - Sub-module rr_next_way: combinational round-robin picker.
//    Inputs: req[N_WAYS], base index, default index. Output: selected index.
//  - Top: phase FSM, timer, lamp decode.
// TESTING (bench overrides: GREEN_MIN=4 GREEN_MAX=8 YELLOW_T=2 ALLRED_T=1)
//  1. Reset held 3 cycles, sensor=0.
//     -> lights all 100 during reset; 1 cycle ALL_RED; then way0 green and held for 50 cycles.
//  2. Way0 green and timer=1, sensor=4'b0100.
//     -> way0 green through timer=3; yellow 2 cycles; all-red 1 cycle; way2 green.
//  3. sensor=4'b1111 constant.
//     -> green order 0,1,2,3,0; each green exactly 4 cycles; yellow 2; all-red 1.
//  4. Way1 green at timer=0, emergency_req=1, emergency_way=3 for 1 cycle.
//     -> yellow next cycle; emergency held through all-red -> way3 green;
//     emergency dropped before all-red -> round-robin pick.
//  5. Emergency for active way2 with sensor=4'b1011 for 20 cycles -> way2 stays green 20 cycles.
//     Release -> yellow after timer>=3 condition.
//  6. Reset during yellow -> all red next cycle, phase 0; then MAIN_WAY green.
//  - Every scenario: assert at most one approach non-red.
//  - Every scenario: assert green is preceded by all-red.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp patterns for the multi-way traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    localparam int unsigned PHASE_W = 2;
    localparam int unsigned LAMP_W  = 3;

    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/rr_next_way.sv
// Combinational round-robin picker: first set req bit after base (base itself last), else dflt.
module rr_next_way #(
    parameter int unsigned N_WAYS = 4,
    parameter int unsigned WAY_W  = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-1:0] req,
    input  logic [WAY_W-1:0]  base,
    input  logic [WAY_W-1:0]  dflt,
    output logic [WAY_W-1:0]  sel
);

    logic [WAY_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester after base wins.
    always_comb begin
        sel = dflt;
        idx = '0;
        for (int unsigned k = N_WAYS; k >= 1; k--) begin
            idx = WAY_W'((32'(base) + k) % N_WAYS);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// N-way intersection light controller: round-robin green grant with min/max green,
// yellow and all-red clearance, plus emergency preemption.
module multi_way_traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned N_WAYS    = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 32,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned MAIN_WAY  = 0,
    localparam int unsigned WAY_W    = $clog2(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_WAYS-1:0]     sensor,
    input  logic                  emergency_req,
    input  logic [WAY_W-1:0]      emergency_way,
    output logic [3*N_WAYS-1:0]   lights,
    output logic [WAY_W-1:0]      active_way,
    output logic [PHASE_W-1:0]    phase
);

    localparam logic [PHASE_W-1:0] S_ALL_RED = PH_ALL_RED;
    localparam logic [PHASE_W-1:0] S_GREEN   = PH_GREEN;
    localparam logic [PHASE_W-1:0] S_YELLOW  = PH_YELLOW;

    logic [CNT_W-1:0]    timer;
    logic [CNT_W-1:0]    timer_n;
    logic [PHASE_W-1:0]  phase_n;
    logic [WAY_W-1:0]    way_n;
    logic [3*N_WAYS-1:0] lights_n;
    logic [N_WAYS-1:0]   others;
    logic [WAY_W-1:0]    rr_sel;
    logic                emerg_valid;
    logic                emerg_self;

    assign emerg_valid = emergency_req && (32'(emergency_way) < N_WAYS);
    assign emerg_self  = emerg_valid && (emergency_way == active_way);
    assign others      = sensor & ~(N_WAYS'(1) << active_way);

    rr_next_way #(
        .N_WAYS (N_WAYS),
        .WAY_W  (WAY_W)
    ) u_rr (
        .req  (sensor),
        .base (active_way),
        .dflt (WAY_W'(MAIN_WAY)),
        .sel  (rr_sel)
    );

    // Next-state, timer and lamp decode.
    always_comb begin
        phase_n  = phase;
        way_n    = active_way;
        timer_n  = timer + CNT_W'(1);
        lights_n = {N_WAYS{LAMP_RED}};
        case (phase)
            S_ALL_RED: begin
                if (timer >= CNT_W'(ALLRED_T - 1)) begin
                    phase_n = S_GREEN;
                    way_n   = emerg_valid ? emergency_way : rr_sel;
                    timer_n = '0;
                end
            end
            S_GREEN: begin
                if (emerg_valid && !emerg_self) begin
                    phase_n = S_YELLOW;
                    timer_n = '0;
                end else if (!emerg_self && (timer >= CNT_W'(GREEN_MIN - 1)) && (others != '0)) begin
                    phase_n = S_YELLOW;
                    timer_n = '0;
                end else if (timer >= CNT_W'(GREEN_MAX - 1)) begin
                    timer_n = timer;
                end
            end
            S_YELLOW: begin
                if (timer >= CNT_W'(YELLOW_T - 1)) begin
                    phase_n = S_ALL_RED;
                    timer_n = '0;
                end
            end
            default: begin
                phase_n = S_ALL_RED;
                timer_n = '0;
            end
        endcase
        for (int unsigned i = 0; i < N_WAYS; i++) begin
            if (WAY_W'(i) == way_n) begin
                if (phase_n == S_GREEN) begin
                    lights_n[3*i +: 3] = LAMP_GRN;
                end else if (phase_n == S_YELLOW) begin
                    lights_n[3*i +: 3] = LAMP_YEL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= S_ALL_RED;
            active_way <= WAY_W'(MAIN_WAY);
            timer      <= '0;
            lights     <= {N_WAYS{LAMP_RED}};
        end else begin
            phase      <= phase_n;
            active_way <= way_n;
            timer      <= timer_n;
            lights     <= lights_n;
        end
    end

endmodule
